split_memory: RTL and testbench
===============================

SPLIT_MEMORY -- requirements
Module: split_memory

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the bits per memory location.
REQ-002 The block SHALL have parameter ADDR_W, default 8, setting the depth of each array to 2^ADDR_W.
REQ-003 The block SHALL have parameter FETCH_BYTES, default 2, giving the locations returned per instruction fetch (range 1..4).
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 busy  output  1  high while the data array is being cleared.
REQ-007 if_en  input  1  instruction fetch request.
REQ-008 if_addr  input  ADDR_W  fetch base address.
REQ-009 if_data  output  FETCH_BYTES*DATA_W  fetched word; location base+k occupies bits [k*DATA_W +: DATA_W].
REQ-010 if_valid  output  1  if_data valid, one-cycle pulse.
REQ-011 ld_we  input  1  program-load write strobe into the instruction array.
REQ-012 ld_addr  input  ADDR_W  program-load address.
REQ-013 ld_data  input  DATA_W  program-load data.
REQ-014 d_req  input  1  data access request; held high until d_ack.
REQ-015 d_we  input  1  1 = write, 0 = read; sampled with d_req.
REQ-016 d_addr  input  ADDR_W  data address.
REQ-017 d_wdata  input  DATA_W  write data.
REQ-018 d_rdata  output  DATA_W  read data, valid while d_ack is high.
REQ-019 d_ack  output  1  access complete, one-cycle pulse.

Function
REQ-020 The block SHALL hold two separate arrays, instr and data, each 2^ADDR_W x DATA_W.
REQ-021 Fetch: if_en high at edge N SHALL give if_valid=1 and if_data = instr[(if_addr+k) mod 2^ADDR_W], k=0..FETCH_BYTES-1, during cycle N+1; if_en low SHALL give if_valid=0 with if_data holding its last value.
REQ-022 Fetch SHALL wrap modulo depth (ADDR_W=8, FETCH_BYTES=2: address 255 returns {instr[0], instr[255]}).
REQ-023 Fetch SHALL operate in every FSM state, including INIT.
REQ-024 ld_we high SHALL write ld_data to instr[ld_addr] at the edge; a same-cycle fetch of that address SHALL return the old value (read-before-write).
REQ-025 Data FSM states: INIT, IDLE, ACK.
REQ-026 INIT: clear counter runs 0..2^ADDR_W-1, writing 0 to data[counter] each cycle with busy=1; after the last address, go to IDLE with busy=0; d_req SHALL be ignored (no ack).
REQ-027 IDLE with d_req=1: accept, latch d_we/d_addr/d_wdata, go to ACK; a write SHALL update data[d_addr] at the accept edge.
REQ-028 ACK: d_ack=1 for exactly one cycle; a read SHALL present data[latched addr] on d_rdata; next state IDLE.
REQ-029 A d_req still high in IDLE right after ACK SHALL be treated as a new request; maximum throughput SHALL be one access per 2 cycles.
REQ-030 Outside ACK, d_rdata SHALL hold its last value and d_ack SHALL be 0.
REQ-031 d_addr/d_wdata changes while in ACK SHALL NOT affect the transaction in flight.

Reset
REQ-032 rst asserted SHALL immediately force state INIT, counter 0, busy=1, d_ack=0, if_valid=0, d_rdata=0, if_data=0.
REQ-033 Reset mid-transaction SHALL abort it without ack, and reset mid-INIT SHALL restart the clear from address 0.
REQ-034 The instr array SHALL NOT be altered by reset; only load writes change it.
REQ-035 After rst deasserts, busy SHALL stay high for exactly 2^ADDR_W cycles.

Verification
REQ-036 Reset, then count cycles -> busy high 256 cycles after deassert (defaults), then every data read returns 0.
REQ-037 Load instr[4]=0x70, instr[5]=0x00; fetch addr 4 -> next cycle if_valid=1, if_data=0x0070.
REQ-038 Load instr[255]=0xAB, instr[0]=0xCD; fetch 255 -> if_data=0xCDAB.
REQ-039 After INIT, write 0x07 to addr 0x1F, then read 0x1F -> d_ack one cycle after each accept, d_rdata=0x07; d_req held continuously -> acks every 2nd cycle.
REQ-040 Assert d_req during INIT -> no ack until busy falls; pulse rst during a pending read -> no ack, INIT restarts, instr contents unchanged.
REQ-041 Same-cycle ld_we and if_en at addr 0x10 (old 0x11, new 0x22) -> if_data low byte 0x11; refetch -> 0x22.

Source files
------------

// File: rtl/split_memory.sv
// Harvard-style memory: an instruction array with multi-location fetch and a
// program-load port, and a data array behind a req/ack handshake with power-on clear.
module split_memory #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int FETCH_BYTES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          busy,
  input  logic                          if_en,
  input  logic [ADDR_W-1:0]             if_addr,
  output logic [FETCH_BYTES*DATA_W-1:0] if_data,
  output logic                          if_valid,
  input  logic                          ld_we,
  input  logic [ADDR_W-1:0]             ld_addr,
  input  logic [DATA_W-1:0]             ld_data,
  input  logic                          d_req,
  input  logic                          d_we,
  input  logic [ADDR_W-1:0]             d_addr,
  input  logic [DATA_W-1:0]             d_wdata,
  output logic [DATA_W-1:0]             d_rdata,
  output logic                          d_ack
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [1:0] S_INIT = 2'd0;
  localparam logic [1:0] S_IDLE = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  logic [DATA_W-1:0]             instr_mem [DEPTH];
  logic [DATA_W-1:0]             data_mem  [DEPTH];

  logic [1:0]                    state_q, state_d;
  logic [ADDR_W-1:0]             clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0]             d_rdata_q, d_rdata_d;
  logic [FETCH_BYTES*DATA_W-1:0] if_data_q, fetch_word;
  logic                          if_valid_q;
  logic                          accept;

  // ---------------------------------------------------------------------------
  // Instruction side: independent of the data FSM, so fetch also works in INIT.
  // ---------------------------------------------------------------------------

  // NOTE: memory arrays carry no reset; clearing a RAM in one cycle is not
  // something real storage can do, and the instr contents must survive reset.
  always_ff @(posedge clk) begin
    if (ld_we) begin
      instr_mem[ld_addr] <= ld_data;
    end
  end

  // Location base+k lands in slice k; the ADDR_W-wide sum wraps at the top.
  always_comb begin
    fetch_word = '0;
    for (int k = 0; k < FETCH_BYTES; k++) begin
      fetch_word[k*DATA_W +: DATA_W] = instr_mem[if_addr + ADDR_W'(k)];
    end
  end

  // Reads the pre-edge array contents, so a same-edge load returns old data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_valid_q <= 1'b0;
      if_data_q  <= '0;
    end else begin
      if_valid_q <= if_en;
      if (if_en) begin
        if_data_q <= fetch_word;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Data side: clear sweep, then one access per two cycles at most.
  // ---------------------------------------------------------------------------

  assign accept = (state_q == S_IDLE) && d_req;

  // NOTE: every variable is given a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    d_rdata_d = d_rdata_q;
    case (state_q)
      S_INIT: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == {ADDR_W{1'b1}}) begin
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (d_req) begin
          state_d = S_ACK;
          // Capturing read data at accept makes later d_addr changes harmless.
          if (!d_we) begin
            d_rdata_d = data_mem[d_addr];
          end
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; the combinational block above uses blocking ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_INIT;
      clr_cnt_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_INIT) begin
      data_mem[clr_cnt_q] <= '0;
    end else if (accept && d_we) begin
      data_mem[d_addr] <= d_wdata;
    end
  end

  assign busy     = (state_q == S_INIT);
  assign d_ack    = (state_q == S_ACK);
  assign d_rdata  = d_rdata_q;
  assign if_data  = if_data_q;
  assign if_valid = if_valid_q;

endmodule

// File: tb/tb_split_memory.sv
// Randomized bench for split_memory against an array-level reference model of
// both memories, with directed steps for reset, clear, wrap and handshake timing.
module tb_split_memory;

  localparam int DW    = 8;
  localparam int AW    = 8;
  localparam int FB    = 2;
  localparam int DEPTH = 1 << AW;

  logic             clk;
  logic             rst;
  logic             busy;
  logic             if_en;
  logic [AW-1:0]    if_addr;
  logic [FB*DW-1:0] if_data;
  logic             if_valid;
  logic             ld_we;
  logic [AW-1:0]    ld_addr;
  logic [DW-1:0]    ld_data;
  logic             d_req;
  logic             d_we;
  logic [AW-1:0]    d_addr;
  logic [DW-1:0]    d_wdata;
  logic [DW-1:0]    d_rdata;
  logic             d_ack;

  int vectors     = 0;
  int miscompares = 0;

  logic [DW-1:0]    instr_m [DEPTH];
  logic [DW-1:0]    data_m  [DEPTH];
  logic [FB*DW-1:0] exp_fetch;
  logic             exp_valid;
  logic [DW-1:0]    exp_rdata;

  split_memory #(.DATA_W(DW), .ADDR_W(AW), .FETCH_BYTES(FB)) dut (
    .clk      (clk),
    .rst      (rst),
    .busy     (busy),
    .if_en    (if_en),
    .if_addr  (if_addr),
    .if_data  (if_data),
    .if_valid (if_valid),
    .ld_we    (ld_we),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_ack    (d_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("miscompare on %s", tag);
    end
  endtask

  // Model a fetch from the arrays as they stand before the edge, then apply
  // the load, then advance one clock and compare the fetch outputs.
  task automatic step();
    logic [AW-1:0] a;
    if (rst) begin
      exp_valid = 1'b0;
      exp_fetch = '0;
    end else begin
      exp_valid = if_en;
      if (if_en) begin
        for (int k = 0; k < FB; k++) begin
          a = if_addr + AW'(k);
          exp_fetch[k*DW +: DW] = instr_m[a];
        end
      end
      if (ld_we) instr_m[ld_addr] = ld_data;
    end
    @(posedge clk);
    #1;
    check("if_valid", {31'd0, if_valid}, {31'd0, exp_valid});
    check("if_data", {16'd0, if_data}, {16'd0, exp_fetch});
  endtask

  task automatic reset_model();
    exp_valid = 1'b0;
    exp_fetch = '0;
    exp_rdata = '0;
    for (int i = 0; i < DEPTH; i++) data_m[i] = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},     {31'd0, busy},     32'd1);
    check({tag, "_d_ack"},    {31'd0, d_ack},    32'd0);
    check({tag, "_if_valid"}, {31'd0, if_valid}, 32'd0);
    check({tag, "_d_rdata"},  {24'd0, d_rdata},  32'd0);
    check({tag, "_if_data"},  {16'd0, if_data},  32'd0);
  endtask

  // Runs until busy falls (bounded); optionally loads the whole instr array
  // and fetches already-loaded addresses while the clear is in progress.
  task automatic count_busy(input bit do_load, output int n);
    n = 0;
    while (busy === 1'b1 && n < 400) begin
      if (do_load) begin
        ld_we   = 1'b1;
        ld_addr = AW'(n);
        ld_data = DW'($urandom);
        if_en   = (n >= 2) ? 1'($urandom) : 1'b0;
        if_addr = (n >= 2) ? AW'($urandom_range(n - 2, 0)) : '0;
      end
      step();
      n++;
      check("init_no_ack", {31'd0, d_ack}, 32'd0);
    end
    ld_we = 1'b0;
    if_en = 1'b0;
  endtask

  task automatic access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    d_req   = 1'b1;
    d_we    = we;
    d_addr  = a;
    d_wdata = wd;
    step();
    check("d_ack_pulse", {31'd0, d_ack}, 32'd1);
    if (we) data_m[a] = wd;
    else    exp_rdata = data_m[a];
    check("d_rdata", {24'd0, d_rdata}, {24'd0, exp_rdata});
    d_req   = 1'b0;
    d_we    = 1'($urandom);
    d_addr  = AW'($urandom);
    d_wdata = DW'($urandom);
    step();
    check("d_ack_drop", {31'd0, d_ack}, 32'd0);
    check("d_rdata_hold", {24'd0, d_rdata}, {24'd0, exp_rdata});
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ld_we   = 1'b1;
    ld_addr = a;
    ld_data = d;
    step();
    ld_we = 1'b0;
  endtask

  task automatic fetch(input logic [AW-1:0] a);
    if_en   = 1'b1;
    if_addr = a;
    step();
    if_en = 1'b0;
  endtask

  initial begin
    int            n;
    logic [AW-1:0] junk_a;
    logic [AW-1:0] ra;

    rst = 1'b1; if_en = 1'b0; if_addr = '0; ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    reset_model();
    #3;
    check_reset_outputs("por");

    // Clear sweep with a write request held throughout; it must be ignored.
    junk_a = AW'($urandom);
    @(negedge clk);
    rst     = 1'b0;
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = junk_a;
    d_wdata = DW'($urandom_range(255, 1));
    count_busy(1'b1, n);
    check("busy_cycles", n, 32'd256);
    d_req = 1'b0;

    access(1'b0, junk_a, '0);
    for (int i = 0; i < 6; i++) access(1'b0, AW'($urandom), '0);

    access(1'b1, 8'h1F, 8'h07);
    access(1'b0, 8'h1F, '0);
    check("rd_1f", {24'd0, d_rdata}, 32'h07);

    // Request held high: an ack on every second cycle.
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 8'h1F;
    for (int i = 0; i < 6; i++) begin
      step();
      check("tput_ack", {31'd0, d_ack}, {31'd0, (i % 2 == 0)});
      if (i % 2 == 0) check("tput_rdata", {24'd0, d_rdata}, 32'h07);
    end
    d_req = 1'b0;
    step();
    exp_rdata = data_m[8'h1F];

    for (int i = 0; i < 20; i++) access(1'($urandom), AW'($urandom), DW'($urandom));

    load(8'd4, 8'h70);
    load(8'd5, 8'h00);
    fetch(8'd4);
    check("fetch4_valid", {31'd0, if_valid}, 32'd1);
    check("fetch4_data", {16'd0, if_data}, 32'h0070);
    step();

    load(8'd255, 8'hAB);
    load(8'd0, 8'hCD);
    fetch(8'd255);
    check("fetch_wrap", {16'd0, if_data}, 32'hCDAB);

    load(8'h10, 8'h11);
    ld_we   = 1'b1;
    ld_addr = 8'h10;
    ld_data = 8'h22;
    fetch(8'h10);
    ld_we = 1'b0;
    check("rbw_old", {24'd0, if_data[7:0]}, 32'h11);
    fetch(8'h10);
    check("rbw_new", {24'd0, if_data[7:0]}, 32'h22);

    for (int i = 0; i < 40; i++) begin
      ld_we   = 1'($urandom);
      ld_addr = AW'($urandom);
      ld_data = DW'($urandom);
      if_en   = 1'($urandom);
      if_addr = AW'($urandom);
      step();
    end
    ld_we = 1'b0;
    if_en = 1'b0;

    // Reset while an ack is showing: it must drop at once.
    ra     = AW'($urandom);
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = ra;
    step();
    check("pre_rst_ack", {31'd0, d_ack}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    reset_model();
    check_reset_outputs("rst_in_ack");
    step();
    step();
    rst = 1'b0;

    // Reset part way through the clear restarts it from address zero.
    for (int i = 0; i < 100; i++) begin
      step();
      check("mid_init_busy", {31'd0, busy}, 32'd1);
      check("mid_init_ack", {31'd0, d_ack}, 32'd0);
    end
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_in_init");
    step();
    rst = 1'b0;
    count_busy(1'b0, n);
    check("busy_cycles_restart", n, 32'd256);
    d_req = 1'b0;

    access(1'b0, ra, '0);
    access(1'b0, 8'h1F, '0);
    for (int a = 0; a < DEPTH; a += 2) fetch(AW'(a));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
